// File: rtl/systolic_os_mf.sv
// Output-stationary NxN systolic multiply tile with int8 or fp16 arithmetic.
// Operands enter skewed per lane, every PE keeps its own accumulator, and the
// finished tile is drained row by row over a valid/ready port.
module systolic_os_mf #(
    parameter int N     = 4,
    parameter int ACC_W = 32,
    parameter int K_W   = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic                 mode,
    input  logic [K_W-1:0]       k_len,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [16*N-1:0]      a_col,
    input  logic [16*N-1:0]      b_row,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [ACC_W*N-1:0]   out_row,
    output logic [$clog2(N)-1:0] out_row_idx,
    output logic                 busy,
    output logic                 done
);

    localparam int R_W  = $clog2(N);
    localparam int FL_W = $clog2(2 * N);
    localparam int SK   = N * (N - 1) / 2;  // lane i owns entries i*(i-1)/2 .. +i-1

    typedef enum logic [1:0] {S_IDLE, S_COMPUTE, S_FLUSH, S_DRAIN} state_t;

    // Signed 8x8 product, sign-extended to the accumulator width.
    function automatic logic [ACC_W-1:0] int8_prod(input logic [15:0] a, input logic [15:0] b);
        logic signed [15:0] p;
        p = 16'($signed(a[7:0])) * 16'($signed(b[7:0]));
        return ACC_W'(p);
    endfunction

    // Truncating fp16 multiply; exponent wraps modulo 32.
    function automatic logic [15:0] fp_mul(input logic [15:0] x, input logic [15:0] y);
        logic [21:0] p;
        logic [4:0]  e;
        p = 22'({1'b1, x[9:0]}) * 22'({1'b1, y[9:0]});
        e = x[14:10] + y[14:10] - 5'd15;
        if (p[21]) return {x[15] ^ y[15], e + 5'd1, p[20:11]};
        return {x[15] ^ y[15], e, p[19:10]};
    endfunction

    // Truncating fp16 add; bit 16 of the result flags an exact zero.
    function automatic logic [16:0] fp_add(input logic [15:0] x, input logic [15:0] y);
        logic [15:0] big, sml;
        logic [4:0]  e;
        logic [10:0] mb, ms, diff;
        logic [11:0] sum;
        logic [3:0]  lz;
        logic        found;
        if (x[14:0] >= y[14:0]) begin
            big = x; sml = y;
        end else begin
            big = y; sml = x;
        end
        e  = big[14:10];
        mb = {1'b1, big[9:0]};
        ms = {1'b1, sml[9:0]} >> (big[14:10] - sml[14:10]);
        if (big[15] == sml[15]) begin
            sum = {1'b0, mb} + {1'b0, ms};
            if (sum[11]) return {1'b0, big[15], e + 5'd1, sum[10:1]};
            return {1'b0, big[15], e, sum[9:0]};
        end
        diff = mb - ms;
        if (diff == '0) return 17'h1_0000;
        lz    = '0;
        found = 1'b0;
        for (int p = 10; p >= 0; p--) begin
            if (!found) begin
                if (diff[p]) found = 1'b1;
                else         lz    = lz + 4'd1;
            end
        end
        diff = diff << lz;
        return {1'b0, big[15], e - {1'b0, lz}, diff[9:0]};
    endfunction

    state_t           state_q, state_d;
    logic             mode_q, mode_d, done_q, done_d, clear_acc, xfer;
    logic [K_W-1:0]   klen_q, klen_d, beat_q, beat_d;
    logic [FL_W-1:0]  flush_q, flush_d;
    logic [R_W-1:0]   row_q, row_d;

    logic [15:0]      sa_q [SK];
    logic [15:0]      sb_q [SK];
    logic             sav_q [SK];
    logic             sbv_q [SK];
    logic [15:0]      a_sk [N];
    logic [15:0]      b_sk [N];
    logic             av_sk [N];
    logic             bv_sk [N];

    logic [15:0]      pa_q [N][N];
    logic [15:0]      pb_q [N][N];
    logic             pav_q [N][N];
    logic             pbv_q [N][N];
    logic [15:0]      a_in [N][N];
    logic [15:0]      b_in [N][N];
    logic             av_in [N][N];
    logic             bv_in [N][N];
    logic [ACC_W-1:0] acc_q [N][N];
    logic [ACC_W-1:0] acc_d [N][N];
    logic             first_q [N][N];
    logic             first_d [N][N];

    assign in_ready    = (state_q == S_COMPUTE);
    assign out_valid   = (state_q == S_DRAIN) && !done_q;
    assign busy        = (state_q != S_IDLE);
    assign done        = done_q;
    assign out_row_idx = row_q;
    assign xfer        = in_valid && in_ready;

    // Job sequencing: latch the job, count beats, time the flush, walk the rows.
    always_comb begin
        // NOTE: every output of this block gets a default first so no latch is inferred.
        state_d   = state_q;
        mode_d    = mode_q;
        klen_d    = klen_q;
        beat_d    = beat_q;
        flush_d   = flush_q;
        row_d     = row_q;
        done_d    = 1'b0;
        clear_acc = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (start && (k_len != '0)) begin
                    state_d   = S_COMPUTE;
                    mode_d    = mode;
                    klen_d    = k_len;
                    beat_d    = '0;
                    clear_acc = 1'b1;
                end
            end
            S_COMPUTE: begin
                if (xfer) begin
                    beat_d = beat_q + 1'b1;
                    if (beat_q == klen_q - 1'b1) begin
                        state_d = S_FLUSH;
                        flush_d = '0;
                    end
                end
            end
            S_FLUSH: begin
                flush_d = flush_q + 1'b1;
                row_d   = '0;
                if (flush_q == FL_W'(2 * N - 2)) state_d = S_DRAIN;
            end
            S_DRAIN: begin
                if (done_q) begin
                    state_d = S_IDLE;
                end else if (out_ready) begin
                    if (row_q == R_W'(N - 1)) begin
                        row_d  = '0;
                        done_d = 1'b1;
                    end else begin
                        row_d = row_q + 1'b1;
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Control registers.
    always_ff @(posedge clk) begin
        // NOTE: state updates use non-blocking assignments so every register samples pre-edge values.
        if (rst) begin
            state_q <= S_IDLE;
            mode_q  <= 1'b0;
            klen_q  <= '0;
            beat_q  <= '0;
            flush_q <= '0;
            row_q   <= '0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            mode_q  <= mode_d;
            klen_q  <= klen_d;
            beat_q  <= beat_d;
            flush_q <= flush_d;
            row_q   <= row_d;
            done_q  <= done_d;
        end
    end

    // Skew delay lines: lane i of A and B is delayed by i cycles.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int k = 0; k < SK; k++) begin
                sa_q[k]  <= '0;
                sb_q[k]  <= '0;
                sav_q[k] <= 1'b0;
                sbv_q[k] <= 1'b0;
            end
        end else begin
            for (int i = 1; i < N; i++) begin
                for (int d = 0; d < i; d++) begin
                    if (d == 0) begin
                        sa_q[i*(i-1)/2]  <= a_col[16*i +: 16];
                        sb_q[i*(i-1)/2]  <= b_row[16*i +: 16];
                        sav_q[i*(i-1)/2] <= xfer;
                        sbv_q[i*(i-1)/2] <= xfer;
                    end else begin
                        sa_q[i*(i-1)/2+d]  <= sa_q[i*(i-1)/2+d-1];
                        sb_q[i*(i-1)/2+d]  <= sb_q[i*(i-1)/2+d-1];
                        sav_q[i*(i-1)/2+d] <= sav_q[i*(i-1)/2+d-1];
                        sbv_q[i*(i-1)/2+d] <= sbv_q[i*(i-1)/2+d-1];
                    end
                end
            end
        end
    end

    // Skew taps feeding the left column and top row of the array.
    always_comb begin
        a_sk[0]  = a_col[15:0];
        b_sk[0]  = b_row[15:0];
        av_sk[0] = xfer;
        bv_sk[0] = xfer;
        for (int i = 1; i < N; i++) begin
            a_sk[i]  = sa_q[i*(i-1)/2 + i - 1];
            b_sk[i]  = sb_q[i*(i-1)/2 + i - 1];
            av_sk[i] = sav_q[i*(i-1)/2 + i - 1];
            bv_sk[i] = sbv_q[i*(i-1)/2 + i - 1];
        end
    end

    // PE operand routing and multiply-accumulate next state.
    always_comb begin
        for (int i = 0; i < N; i++) begin
            for (int j = 0; j < N; j++) begin
                logic [16:0] fsum;
                logic [15:0] fprod;
                if (j == 0) begin
                    a_in[i][j]  = a_sk[i];
                    av_in[i][j] = av_sk[i];
                end else begin
                    a_in[i][j]  = pa_q[i][j-1];
                    av_in[i][j] = pav_q[i][j-1];
                end
                if (i == 0) begin
                    b_in[i][j]  = b_sk[j];
                    bv_in[i][j] = bv_sk[j];
                end else begin
                    b_in[i][j]  = pb_q[i-1][j];
                    bv_in[i][j] = pbv_q[i-1][j];
                end
                fprod         = fp_mul(a_in[i][j], b_in[i][j]);
                fsum          = fp_add(acc_q[i][j][15:0], fprod);
                acc_d[i][j]   = acc_q[i][j];
                first_d[i][j] = first_q[i][j];
                if (clear_acc) begin
                    acc_d[i][j]   = '0;
                    first_d[i][j] = 1'b1;
                end else if (av_in[i][j] && bv_in[i][j]) begin
                    if (!mode_q) begin
                        acc_d[i][j] = acc_q[i][j] + int8_prod(a_in[i][j], b_in[i][j]);
                    end else if (first_q[i][j]) begin
                        acc_d[i][j]   = ACC_W'(fprod);
                        first_d[i][j] = 1'b0;
                    end else begin
                        acc_d[i][j]   = ACC_W'(fsum[15:0]);
                        first_d[i][j] = fsum[16];
                    end
                end
            end
        end
    end

    // PE registers: operand pipes plus stationary accumulators.
    always_ff @(posedge clk) begin
        // NOTE: the accumulator array is reset explicitly because an abandoned job must leave no residue.
        if (rst) begin
            for (int i = 0; i < N; i++) begin
                for (int j = 0; j < N; j++) begin
                    pa_q[i][j]    <= '0;
                    pb_q[i][j]    <= '0;
                    pav_q[i][j]   <= 1'b0;
                    pbv_q[i][j]   <= 1'b0;
                    acc_q[i][j]   <= '0;
                    first_q[i][j] <= 1'b1;
                end
            end
        end else begin
            for (int i = 0; i < N; i++) begin
                for (int j = 0; j < N; j++) begin
                    pa_q[i][j]    <= a_in[i][j];
                    pb_q[i][j]    <= b_in[i][j];
                    pav_q[i][j]   <= av_in[i][j];
                    pbv_q[i][j]   <= bv_in[i][j];
                    acc_q[i][j]   <= acc_d[i][j];
                    first_q[i][j] <= first_d[i][j];
                end
            end
        end
    end

    // Result row mux; zero whenever no row is being offered.
    always_comb begin
        out_row = '0;
        for (int j = 0; j < N; j++) begin
            if (out_valid) out_row[ACC_W*j +: ACC_W] = acc_q[row_q][j];
        end
    end

endmodule

// File: tb/tb_systolic_os_mf.sv
// Scoreboard bench for systolic_os_mf: a 32-bit and a 16-bit accumulator build
// share the same stimulus; expected rows come from an independent model.
module tb_systolic_os_mf;

    localparam int N   = 4;
    localparam int K_W = 8;

    logic             clk = 1'b0;
    logic             rst, start, mode, in_valid, out_ready;
    logic [K_W-1:0]   k_len;
    logic [16*N-1:0]  a_col, b_row;
    logic             in_ready, out_valid, busy, done;
    logic [32*N-1:0]  out_row;
    logic [1:0]       out_row_idx;
    logic             in_ready16, out_valid16, busy16, done16;
    logic [16*N-1:0]  out_row16;
    logic [1:0]       out_row_idx16;

    systolic_os_mf #(.N(N), .ACC_W(32), .K_W(K_W)) dut (
        .clk(clk), .rst(rst), .start(start), .mode(mode), .k_len(k_len),
        .in_valid(in_valid), .in_ready(in_ready), .a_col(a_col), .b_row(b_row),
        .out_valid(out_valid), .out_ready(out_ready), .out_row(out_row),
        .out_row_idx(out_row_idx), .busy(busy), .done(done)
    );

    systolic_os_mf #(.N(N), .ACC_W(16), .K_W(K_W)) dut16 (
        .clk(clk), .rst(rst), .start(start), .mode(mode), .k_len(k_len),
        .in_valid(in_valid), .in_ready(in_ready16), .a_col(a_col), .b_row(b_row),
        .out_valid(out_valid16), .out_ready(out_ready), .out_row(out_row16),
        .out_row_idx(out_row_idx16), .busy(busy16), .done(done16)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_checks = 0;
    int n_fail   = 0;

    typedef struct {
        logic [1:0]      idx;
        logic [32*N-1:0] row;
    } exp_t;

    exp_t            sb[$];
    logic [16*N-1:0] ja[$];
    logic [16*N-1:0] jb[$];

    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic real h2r(input logic [15:0] h);
        real v;
        int  e;
        v = 1.0 + real'(h[9:0]) / 1024.0;
        e = int'(h[14:10]) - 15;
        while (e > 0) begin v = v * 2.0; e--; end
        while (e < 0) begin v = v / 2.0; e++; end
        return h[15] ? -v : v;
    endfunction

    function automatic logic [15:0] r2h(input real r);
        real  mag;
        int   e, m;
        logic s;
        if (r == 0.0) return 16'h0000;
        s   = (r < 0.0);
        mag = s ? -r : r;
        e   = 15;
        while (mag >= 2.0) begin mag = mag / 2.0; e++; end
        while (mag < 1.0)  begin mag = mag * 2.0; e--; end
        m = $rtoi((mag - 1.0) * 1024.0);
        return {s, 5'(e), 10'(m)};
    endfunction

    function automatic logic [16*N-1:0] fill(input logic [15:0] v);
        logic [16*N-1:0] r;
        for (int l = 0; l < N; l++) r[16*l +: 16] = v;
        return r;
    endfunction

    // Reference C = A x B over the queued beats, pushed one entry per row.
    task automatic push_expected(input logic m);
        exp_t            e;
        logic [16*N-1:0] av, bv;
        logic [15:0]     ah, bh;
        logic signed [7:0] x, y;
        int              acc;
        real             r;
        for (int i = 0; i < N; i++) begin
            e.idx = 2'(i);
            e.row = '0;
            for (int j = 0; j < N; j++) begin
                acc = 0;
                r   = 0.0;
                for (int k = 0; k < ja.size(); k++) begin
                    av = ja[k];
                    bv = jb[k];
                    ah = av[16*i +: 16];
                    bh = bv[16*j +: 16];
                    x  = ah[7:0];
                    y  = bh[7:0];
                    acc = acc + int'(x) * int'(y);
                    r   = r + h2r(ah) * h2r(bh);
                end
                e.row[32*j +: 32] = m ? {16'h0000, r2h(r)} : acc;
            end
            sb.push_back(e);
        end
    endtask

    task automatic run_job(input string name, input logic m, input logic [31:0] vpat, input int stall);
        int               k, beat, waited, rows, t_last;
        logic             fire;
        exp_t             e;
        logic [16*N-1:0]  exp16;
        k = ja.size();
        push_expected(m);
        start = 1'b1;
        mode  = m;
        k_len = K_W'(k);
        @(posedge clk); #1;
        start = 1'b0;
        mode  = ~m;
        k_len = K_W'($urandom_range(0, 9));
        check({name, "_busy"}, busy, 1'b1);
        beat   = 0;
        waited = 0;
        t_last = cyc;
        while (beat < k && waited < 200) begin
            in_valid = (waited < 32) ? vpat[waited] : 1'b1;
            for (int l = 0; l < N; l++) begin
                a_col[16*l +: 16] = 16'($urandom);
                b_row[16*l +: 16] = 16'($urandom);
            end
            if (in_valid) begin
                a_col = ja[beat];
                b_row = jb[beat];
            end
            fire = in_valid && in_ready;
            if (fire) t_last = cyc;
            @(posedge clk); #1;
            if (fire) beat++;
            waited++;
        end
        in_valid = 1'b0;
        check({name, "_beats"}, beat, k);
        check({name, "_in_ready_flush"}, in_ready, 1'b0);
        out_ready = (stall == 0);
        waited = 0;
        while (!out_valid && waited < 100) begin
            @(posedge clk); #1;
            waited++;
        end
        check({name, "_first_row_latency"}, cyc - t_last, 2 * N);
        for (int s = 0; s < stall; s++) begin
            check({name, "_stall_valid"}, out_valid, 1'b1);
            check({name, "_stall_idx"}, out_row_idx, 2'd0);
            check({name, "_stall_row"}, out_row, sb.size() > 0 ? sb[0].row : '0);
            @(posedge clk); #1;
        end
        out_ready = 1'b1;
        rows   = 0;
        waited = 0;
        while (rows < N && waited < 100) begin
            if (out_valid) begin
                e = sb.pop_front();
                for (int l = 0; l < N; l++) exp16[16*l +: 16] = e.row[32*l +: 16];
                check({name, "_idx"}, out_row_idx, e.idx);
                check({name, "_row"}, out_row, e.row);
                check({name, "_row16"}, out_row16, exp16);
                rows++;
            end
            @(posedge clk); #1;
            waited++;
        end
        check({name, "_rows"}, rows, N);
        check({name, "_done_pulse"}, done, 1'b1);
        check({name, "_valid_after_last"}, out_valid, 1'b0);
        @(posedge clk); #1;
        check({name, "_done_cleared"}, done, 1'b0);
        check({name, "_idle"}, busy, 1'b0);
        check({name, "_job_time"}, cyc - t_last, 3 * N + 1 + stall);
        out_ready = 1'b0;
        sb.delete();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [15:0] fpv [6];
        logic [16*N-1:0] v;
        fpv = '{16'h3C00, 16'h4000, 16'h3800, 16'h3E00, 16'hBC00, 16'h4200};
        rst = 1'b1; start = 1'b0; mode = 1'b0; k_len = '0;
        in_valid = 1'b0; out_ready = 1'b0; a_col = '0; b_row = '0;
        repeat (3) @(posedge clk);
        #1;
        check("reset_busy", busy, 1'b0);
        check("reset_in_ready", in_ready, 1'b0);
        check("reset_out_valid", out_valid, 1'b0);
        check("reset_done", done, 1'b0);
        check("reset_out_row", out_row, '0);
        check("reset_out_idx", out_row_idx, 2'd0);
        rst = 1'b0;
        @(posedge clk); #1;

        // int8: 3 x -2 over two beats -> -12 everywhere
        ja.delete(); jb.delete();
        repeat (2) begin ja.push_back(fill(16'h0003)); jb.push_back(fill(16'hFFFE)); end
        run_job("int8_neg", 1'b0, 32'hFFFF_FFFF, 0);

        // fp16: 1.0 x 2.0 twice -> 4.0, with a 5-cycle output stall
        ja.delete(); jb.delete();
        repeat (2) begin ja.push_back(fill(16'h3C00)); jb.push_back(fill(16'h4000)); end
        run_job("fp16_four", 1'b1, 32'hFFFF_FFFF, 5);

        // fp16: 2.0 + (-2.0) -> exact zero
        ja.delete(); jb.delete();
        ja.push_back(fill(16'h3C00)); jb.push_back(fill(16'h4000));
        ja.push_back(fill(16'h3C00)); jb.push_back(fill(16'hC000));
        run_job("fp16_zero", 1'b1, 32'hFFFF_FFFF, 0);

        // int8 values 1,2,3 with input gaps, then the same without gaps
        ja.delete(); jb.delete();
        for (int k = 1; k <= 3; k++) begin
            ja.push_back(fill(16'(k))); jb.push_back(fill(16'(k)));
        end
        run_job("int8_gaps", 1'b0, 32'hFFFF_FFE9, 0);
        run_job("int8_nogaps", 1'b0, 32'hFFFF_FFFF, 0);

        // int8: (-128)^2 four times -> 0x10000, wraps to 0 in the 16-bit build
        ja.delete(); jb.delete();
        repeat (4) begin ja.push_back(fill(16'h0080)); jb.push_back(fill(16'h0080)); end
        run_job("int8_wrap", 1'b0, 32'hFFFF_FFFF, 0);

        // reset mid-COMPUTE
        start = 1'b1; mode = 1'b0; k_len = K_W'(4);
        @(posedge clk); #1;
        start = 1'b0; in_valid = 1'b1;
        a_col = fill(16'h0011); b_row = fill(16'h0022);
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b1; in_valid = 1'b0;
        @(posedge clk); #1;
        check("rst_mid_busy", busy, 1'b0);
        check("rst_mid_in_ready", in_ready, 1'b0);
        check("rst_mid_out_valid", out_valid, 1'b0);
        check("rst_mid_done", done, 1'b0);
        check("rst_mid_out_row", out_row, '0);
        check("rst_mid_out_idx", out_row_idx, 2'd0);
        rst = 1'b0;
        @(posedge clk); #1;

        // start with zero length is ignored
        start = 1'b1; k_len = '0;
        @(posedge clk); #1;
        start = 1'b0;
        check("zero_k_busy", busy, 1'b0);
        check("zero_k_in_ready", in_ready, 1'b0);
        @(posedge clk); #1;
        check("zero_k_done", done, 1'b0);

        // random int8 operands with random gaps and a short stall
        ja.delete(); jb.delete();
        repeat (6) begin
            for (int l = 0; l < N; l++) v[16*l +: 16] = 16'($urandom);
            ja.push_back(v);
            for (int l = 0; l < N; l++) v[16*l +: 16] = 16'($urandom);
            jb.push_back(v);
        end
        run_job("int8_random", 1'b0, $urandom | 32'h1, 2);

        // fp16 with distinct per-lane values, mixed signs
        ja.delete(); jb.delete();
        for (int k = 0; k < 3; k++) begin
            for (int l = 0; l < N; l++) v[16*l +: 16] = fpv[(l + k) % 6];
            ja.push_back(v);
            for (int l = 0; l < N; l++) v[16*l +: 16] = fpv[(2 * l + k + 1) % 6];
            jb.push_back(v);
        end
        run_job("fp16_mixed", 1'b1, 32'hFFFF_FFFF, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
